// File: rtl/bcp_pkg.sv
// Shared BCP definitions: table geometry, VST row map and decision-unit states.
package bcp_pkg;

  localparam int VAR_NUM     = 8;
  localparam int VAR_NUM_LOG = 3;

  localparam logic [2:0] VST_ROW_FREE = 3'd0;
  localparam logic [2:0] VST_ROW_POL  = 3'd1;
  localparam logic [2:0] VST_ROW_VAL  = 3'd2;

  typedef enum logic [2:0] {
    DEC_IDLE,
    DEC_ARB,
    DEC_RD_FREE,
    DEC_RD_POL,
    DEC_RD_VAL,
    DEC_WR_VAL,
    DEC_CLR_FREE,
    DEC_DONE
  } dec_state_t;

endpackage

// File: rtl/first_free_encoder.sv
// Lowest-set-bit priority encoder (bit 0 wins); shared by the decision and scan paths.
module first_free_encoder #(
  parameter int VAR_NUM = 8,
  parameter int IDX_W   = (VAR_NUM > 1) ? $clog2(VAR_NUM) : 1
) (
  input  logic [VAR_NUM-1:0] free_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  // Scanning downwards lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx_o = '0;
    for (int i = VAR_NUM - 1; i >= 0; i--) begin
      if (free_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign any_o = |free_i;

endmodule

// File: rtl/vst_decision_unit.sv
// Decision initiator: reads the free/polarity/value rows of the VST, assigns the
// lowest free variable its preferred polarity and reports the choice.
module vst_decision_unit #(
  parameter int VAR_NUM     = bcp_pkg::VAR_NUM,
  parameter int VAR_NUM_LOG = bcp_pkg::VAR_NUM_LOG
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dec_req,
  output logic                   dec_valid,
  output logic                   dec_none,
  output logic [VAR_NUM_LOG-1:0] dec_var,
  output logic                   dec_pol,
  output logic                   busy,
  output logic                   vst_req,
  input  logic                   vst_gnt,
  output logic                   vst_en,
  output logic                   vst_write,
  output logic                   vst_bcp_write,
  output logic [2:0]             vst_address,
  output logic [VAR_NUM-1:0]     vst_in,
  output logic [VAR_NUM_LOG-1:0] rewrite_free_bit,
  input  logic [VAR_NUM-1:0]     vst_out
);

  import bcp_pkg::*;

  dec_state_t             state_q, state_d;
  logic [VAR_NUM_LOG-1:0] sel_q, sel_d;
  logic                   pol_q, pol_d;
  logic                   none_q, none_d;

  logic [VAR_NUM_LOG-1:0] enc_idx;
  logic                   enc_any;
  logic [VAR_NUM-1:0]     sel_mask;

  first_free_encoder #(
    .VAR_NUM (VAR_NUM),
    .IDX_W   (VAR_NUM_LOG)
  ) u_first_free (
    .free_i (vst_out),
    .idx_o  (enc_idx),
    .any_o  (enc_any)
  );

  assign sel_mask = VAR_NUM'(1) << sel_q;

  // NOTE: state registers use non-blocking assignments and an asynchronous reset,
  // so every output derived from state_q clears the instant rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DEC_IDLE;
      sel_q   <= '0;
      pol_q   <= 1'b0;
      none_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      pol_q   <= pol_d;
      none_q  <= none_d;
    end
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d          = state_q;
    sel_d            = sel_q;
    pol_d            = pol_q;
    none_d           = none_q;
    dec_valid        = 1'b0;
    dec_none         = 1'b0;
    dec_var          = '0;
    dec_pol          = 1'b0;
    vst_req          = 1'b0;
    vst_en           = 1'b0;
    vst_write        = 1'b0;
    vst_bcp_write    = 1'b0;
    vst_address      = '0;
    vst_in           = '0;
    rewrite_free_bit = '0;

    unique case (state_q)
      DEC_IDLE: begin
        if (dec_req) begin
          none_d  = 1'b0;
          state_d = DEC_ARB;
        end
      end

      DEC_ARB: begin
        vst_req = 1'b1;
        if (vst_gnt) state_d = DEC_RD_FREE;
      end

      DEC_RD_FREE: begin
        vst_req     = 1'b1;
        vst_en      = 1'b1;
        vst_address = VST_ROW_FREE;
        state_d     = DEC_RD_POL;
      end

      // vst_out holds the free mask only in this cycle; the choice is made now.
      DEC_RD_POL: begin
        vst_req     = 1'b1;
        vst_en      = 1'b1;
        vst_address = VST_ROW_POL;
        sel_d       = enc_idx;
        if (!enc_any) begin
          none_d  = 1'b1;
          state_d = DEC_DONE;
        end else begin
          state_d = DEC_RD_VAL;
        end
      end

      DEC_RD_VAL: begin
        vst_req     = 1'b1;
        vst_en      = 1'b1;
        vst_address = VST_ROW_VAL;
        pol_d       = vst_out[sel_q];
        state_d     = DEC_WR_VAL;
      end

      DEC_WR_VAL: begin
        vst_req       = 1'b1;
        vst_en        = 1'b1;
        vst_bcp_write = 1'b1;
        vst_address   = VST_ROW_VAL;
        vst_in        = (vst_out & ~sel_mask) | (pol_q ? sel_mask : '0);
        state_d       = DEC_CLR_FREE;
      end

      DEC_CLR_FREE: begin
        vst_req          = 1'b1;
        vst_en           = 1'b1;
        vst_write        = 1'b1;
        vst_address      = VST_ROW_FREE;
        rewrite_free_bit = sel_q;
        state_d          = DEC_DONE;
      end

      DEC_DONE: begin
        dec_valid = 1'b1;
        dec_none  = none_q;
        dec_var   = none_q ? '0 : sel_q;
        dec_pol   = none_q ? 1'b0 : pol_q;
        state_d   = DEC_IDLE;
      end

      default: state_d = DEC_IDLE;
    endcase
  end

  assign busy = (state_q != DEC_IDLE);

endmodule

// File: doc/vst_decision_unit.md
# vst_decision_unit

Decision-side initiator for the BCP unit's variable state table (VST). On a request, it arbitrates for the VST port and reads the free, polarity and value rows. It then picks the lowest-index free variable, writes that variable's preferred polarity into the value row, clears its free bit, and returns the chosen variable to the solver control. It drives the VST's command port (`vst_en`, `vst_write`, `vst_bcp_write`, `vst_address`, `vst_in`, `rewrite_free_bit`) and consumes its registered `vst_out`.

## Interface
Parameters:
- `VAR_NUM`, 8, number of variables / VST row width
- `VAR_NUM_LOG`, 3, index width, equal to log2(`VAR_NUM`)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `dec_req`  in  1  start a decision; sampled in IDLE only
- `dec_valid`  out  1  one-cycle pulse; result valid
- `dec_none`  out  1  valid with `dec_valid`; no free variable (all assigned)
- `dec_var`  out  `VAR_NUM_LOG`  chosen variable index
- `dec_pol`  out  1  chosen polarity
- `busy`  out  1  high in every state except IDLE
- `vst_req`  out  1  request for the VST port
- `vst_gnt`  in  1  grant; once given, held until `vst_req` drops
- `vst_en`, `vst_write`, `vst_bcp_write`  out  1 each  VST command strobes
- `vst_address`  out  3  VST row address
- `vst_in`  out  `VAR_NUM`  full-row write data
- `rewrite_free_bit`  out  `VAR_NUM_LOG`  bit index for a single-bit clear
- `vst_out`  in  `VAR_NUM`  VST read data, valid the cycle after a read command

## Operation
- VST row map:
  - Row 0 = free mask (1 = unassigned).
  - Row 1 = preferred polarity.
  - Row 2 = assigned value.
- VST command encoding:
  - Read: `vst_en`=1, both write strobes 0.
  - Row write: `vst_en`=1, `vst_bcp_write`=1.
  - Bit clear: `vst_en`=1, `vst_write`=1.
- States: IDLE, ARB, RD_FREE, RD_POL, RD_VAL, WR_VAL, CLR_FREE, DONE.
- IDLE: all outputs 0. If `dec_req`=1, go to ARB.
- ARB: `vst_req`=1. If `vst_gnt`=1, go to RD_FREE; otherwise stay.
- RD_FREE: issue a read of row 0.
- RD_POL: sample `vst_out` as the free mask.
  - Issue a read of row 1.
  - Register `sel` = lowest set bit index (priority encode, bit 0 highest priority).
  - If the mask is 0, set the none flag and go to DONE; otherwise go to RD_VAL.
- RD_VAL: sample `vst_out` as the polarity row and register `pol` = bit `sel`. Issue a read of row 2.
- WR_VAL: sample `vst_out` as the value row. Row-write row 2 with that value, bit `sel` replaced by `pol`.
- CLR_FREE: bit-clear row 0 with `rewrite_free_bit`=`sel`.
- DONE: `dec_valid`=1 for one cycle with `dec_var`/`dec_pol` (or `dec_none`=1). Then go to IDLE.
  - `vst_req` drops in this state.
  - With `dec_none`=1, `dec_var` and `dec_pol` are 0.
- `vst_req`=1 in ARB through CLR_FREE, or ARB through RD_POL on the none path.
- Outside access states: `vst_en`=0, `vst_address`=0, `vst_in`=0, `rewrite_free_bit`=0.
- `dec_req` in any non-IDLE state is ignored; it is not queued.

## Timing
- Reset (asynchronous): state IDLE; every output 0; `sel` and `pol` 0.
- With `dec_req` in cycle 0 and `vst_gnt` already high in cycle 1:
  - `vst_req` rises in cycle 1.
  - Commands: read row 0 in c2, read row 1 in c3, read row 2 in c4, row write in c5, bit clear in c6.
  - `dec_valid` in c7.
- None path: `dec_valid` + `dec_none` in c4.
- Each cycle of `vst_gnt` low in ARB adds one cycle to every subsequent event.
- Read data is taken only in the cycle directly after its read command. The VST zeroes `vst_out` when `vst_en` is low, so data is never re-sampled later.
- Reset mid-sequence: immediate return to IDLE and all outputs 0. A row-2 write or bit clear not yet issued is never issued.
- Back-to-back: after DONE, a new `dec_req` is accepted in the following IDLE cycle. The minimum period is 8 cycles.

## Structure
- Shared package `bcp_pkg`:
  - `VAR_NUM` and `VAR_NUM_LOG`.
  - Row constants `VST_ROW_FREE`=0, `VST_ROW_POL`=1, `VST_ROW_VAL`=2.
  - State enum `dec_state_t`.
- Sub-module `first_free_encoder`: combinational lowest-set-bit encoder, parameterised by `VAR_NUM`. Outputs index and `any`. Also reused by the BCP scan logic.

## Test plan
- Reset with `dec_req`=0 -> all outputs 0, `busy`=0; assert `rst` asynchronously mid-cycle -> outputs clear without a clock edge.
- VST at reset contents (free=0xFF, pol=0xFF, val=0x00), gnt immediate -> row write of 0x01 to row 2 in c5, clear bit 0 of row 0 in c6, `dec_valid` c7 with `dec_var`=0, `dec_pol`=1.
- free=0xA0, pol=0x00, val=0xFF -> row-2 write 0xDF, clear bit 5, `dec_var`=5, `dec_pol`=0.
- free=0x00 -> no write or clear commands; `dec_valid`+`dec_none` in c4.
- `vst_gnt` held low 3 cycles -> every VST command and `dec_valid` shifted by exactly 3 cycles; `vst_en`=0 throughout ARB.
- `rst` pulsed during WR_VAL -> no CLR_FREE command issued, outputs 0; a following `dec_req` runs a full clean sequence. `dec_req` pulsed while `busy` -> ignored.
